// File: rtl/signmag_decode_serial.sv
`default_nettype none
// ============================================================================
// Module      : signmag_decode_serial
// Description : Bit-serial two's-complement to sign/magnitude decoder.
//               One bit per clock, LSB first: bits are copied up to and
//               including the first 1, later bits are inverted when the
//               operand is negative. Valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module signmag_decode_serial #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-1:0] out_mag,
  output logic             out_overflow
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Counter value on the edge that processes the MSB.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             sign_r;
  logic             seen_one;

  logic             bit_cur;
  logic             bit_out;
  logic [WIDTH-1:0] acc_next;

  // Serial complement: positive words pass through; negative words copy
  // bits through the first 1 and invert everything above it.
  assign bit_cur  = sreg[0];
  assign bit_out  = (sign_r && seen_one) ? ~bit_cur : bit_cur;
  assign acc_next = {bit_out, acc[WIDTH-1:1]};

  // A word may only be taken while idle.
  assign in_ready = (state == IDLE);

  // Handshake FSM, serial datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sreg         <= '0;
      acc          <= '0;
      cnt          <= '0;
      sign_r       <= 1'b0;
      seen_one     <= 1'b0;
      out_valid    <= 1'b0;
      out_sign     <= 1'b0;
      out_mag      <= '0;
      out_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sreg     <= in_data;
            sign_r   <= in_data[WIDTH-1];
            cnt      <= '0;
            seen_one <= 1'b0;
            acc      <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          sreg     <= sreg >> 1;
          acc      <= acc_next;
          seen_one <= seen_one | bit_cur;
          cnt      <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            // MSB of the magnitude can only be set for the most negative word.
            out_mag      <= acc_next;
            out_sign     <= sign_r;
            out_overflow <= sign_r & bit_out;
            out_valid    <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_signmag_decode_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_signmag_decode_serial
// Description : Self-checking bench for signmag_decode_serial with directed
//               boundary cases, backpressure, reset abort and random words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_signmag_decode_serial;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_sign;
  logic [W-1:0] out_mag;
  logic         out_overflow;

  int tests  = 0;
  int failed = 0;

  signmag_decode_serial #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sign     (out_sign),
    .out_mag      (out_mag),
    .out_overflow (out_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: sign is the MSB, magnitude is |x| modulo 2^W, overflow only
  // for the most negative value.
  function automatic void model(input logic [W-1:0] x, output logic s,
                                output logic [W-1:0] m, output logic o);
    int signed v;
    v = int'($signed(x));
    s = (v < 0);
    m = (v < 0) ? W'(-v) : W'(v);
    o = (x == {1'b1, {(W-1){1'b0}}});
  endfunction

  // Push one word through and collect observations. Called at #1 after a
  // rising edge. busy_err flags in_ready seen high while busy or outputs
  // moving during the stall; rel_ok reports the state after out_ready.
  task automatic do_word(input logic [W-1:0] d, input int stall,
                         output int lat, output logic s, output logic [W-1:0] m,
                         output logic o, output logic busy_err,
                         output logic timeout, output logic rel_ok);
    int waitc;
    lat = 0; busy_err = 1'b0; timeout = 1'b0; rel_ok = 1'b0;
    s = 1'b0; m = '0; o = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    waitc = 0;
    while (!in_ready && waitc < 100) begin
      @(posedge clk); #1; waitc++;
    end
    if (!in_ready) begin
      timeout = 1'b1;
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = W'($urandom);
    while (!out_valid) begin
      if (in_ready) busy_err = 1'b1;
      @(posedge clk); #1;
      lat++;
      if (lat > 100) begin
        timeout = 1'b1;
        return;
      end
    end
    s = out_sign; m = out_mag; o = out_overflow;
    for (int i = 0; i < stall; i++) begin
      if (in_ready || !out_valid) busy_err = 1'b1;
      @(posedge clk); #1;
      if (out_sign !== s || out_mag !== m || out_overflow !== o) busy_err = 1'b1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    rel_ok = (out_valid === 1'b0) && (in_ready === 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({in_ready, out_valid, out_sign, out_mag, out_overflow} !== {1'b1, 1'b0, 1'b0, 16'h0, 1'b0}) begin
      failed++;
      $display("FAIL reset_values: got rdy=%b vld=%b sgn=%b mag=%h ovf=%b, need 1 0 0 0000 0",
               in_ready, out_valid, out_sign, out_mag, out_overflow);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] vec [6] = '{16'h0005, 16'hFFFB, 16'hFFFF, 16'h8000, 16'h0000, 16'h7FFF};
    logic [W-1:0] exp_m [6] = '{16'h0005, 16'h0005, 16'h0001, 16'h8000, 16'h0000, 16'h7FFF};
    logic exp_s [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic exp_o [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int lat; logic s, o, be, to, rel; logic [W-1:0] m;
    for (int i = 0; i < 6; i++) begin
      do_word(vec[i], 0, lat, s, m, o, be, to, rel);
      tests++;
      if (to !== 1'b0 || lat != W) begin
        failed++;
        $display("FAIL directed_latency[%h]: got lat=%0d timeout=%b, need lat=%0d", vec[i], lat, to, W);
      end
      tests++;
      if (s !== exp_s[i] || m !== exp_m[i] || o !== exp_o[i]) begin
        failed++;
        $display("FAIL directed_result[%h]: got s=%b m=%h o=%b, need s=%b m=%h o=%b",
                 vec[i], s, m, o, exp_s[i], exp_m[i], exp_o[i]);
      end
      tests++;
      if (be !== 1'b0 || rel !== 1'b1) begin
        failed++;
        $display("FAIL directed_handshake[%h]: got busy_err=%b release_ok=%b, need 0 1", vec[i], be, rel);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    in_valid = 1'b1; in_data = 16'hFFF0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    tests++;
    if (lat != W) begin
      failed++;
      $display("FAIL bp_latency: got %0d, need %0d", lat, W);
    end
    // Offer another word while the result is stalled; it must be ignored.
    in_valid = 1'b1; in_data = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sign !== 1'b1 ||
          out_mag !== 16'h0010 || out_overflow !== 1'b0) begin
        failed++;
        $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b s=%b m=%h o=%b, need 1 0 1 0010 0",
                 i, out_valid, in_ready, out_sign, out_mag, out_overflow);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_mag !== 16'h0010) begin
      failed++;
      $display("FAIL bp_release: got rdy=%b vld=%b m=%h, need 1 0 0010", in_ready, out_valid, out_mag);
    end
    // out_ready in IDLE does nothing and no stray word was taken.
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failed++;
      $display("FAIL bp_idle_stable: got rdy=%b vld=%b, need 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_abort();
    int lat; logic s, o, be, to, rel; logic [W-1:0] m;
    logic saw_valid;
    in_valid = 1'b1; in_data = 16'h1234;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_mag !== 16'h0 || out_sign !== 1'b0) begin
      failed++;
      $display("FAIL abort_state: got rdy=%b vld=%b s=%b m=%h, need 1 0 0 0000",
               in_ready, out_valid, out_sign, out_mag);
    end
    @(negedge clk); rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (W + 4) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    tests++;
    if (saw_valid !== 1'b0) begin
      failed++;
      $display("FAIL abort_no_pulse: got out_valid pulse=%b, need 0", saw_valid);
    end
    do_word(16'hFFFF, 1, lat, s, m, o, be, to, rel);
    tests++;
    if (to !== 1'b0 || s !== 1'b1 || m !== 16'h0001 || o !== 1'b0) begin
      failed++;
      $display("FAIL abort_recover: got to=%b s=%b m=%h o=%b, need 0 1 0001 0", to, s, m, o);
    end
  endtask

  task automatic test_random();
    int lat; logic s, o, be, to, rel; logic [W-1:0] m;
    logic es, eo; logic [W-1:0] em, d;
    for (int n = 0; n < 1000; n++) begin
      d = W'($urandom);
      if (n % 50 == 0) d = 16'h8000;
      model(d, es, em, eo);
      do_word(d, int'($urandom_range(0, 3)), lat, s, m, o, be, to, rel);
      tests++;
      if (to !== 1'b0 || lat != W) begin
        failed++;
        $display("FAIL rand_latency[%0d] %h: got lat=%0d to=%b, need %0d", n, d, lat, to, W);
      end
      tests++;
      if (s !== es || m !== em || o !== eo) begin
        failed++;
        $display("FAIL rand_result[%0d] %h: got s=%b m=%h o=%b, need s=%b m=%h o=%b",
                 n, d, s, m, o, es, em, eo);
      end
      tests++;
      if (be !== 1'b0 || rel !== 1'b1) begin
        failed++;
        $display("FAIL rand_handshake[%0d] %h: got busy_err=%b release_ok=%b, need 0 1", n, d, be, rel);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
